// File: rtl/dma_pkg.sv
// -----------------------------------------------------------------------------
// dma_pkg
// Shared types and constants for the DMA channel register file:
//   - register offsets of the global block (relative to 2*NUM_CH)
//   - transfer-type and operating-mode enums
//   - per-channel mode record and command register layout
//   - helper deciding when a channel's address counter is frozen
// -----------------------------------------------------------------------------
package dma_pkg;

    // Global register offsets, counted from the first address after the
    // per-channel address/count pairs.
    localparam logic [3:0] OFF_CMD      = 4'd0;  // W: command, R: status
    localparam logic [3:0] OFF_REQ      = 4'd1;  // software request
    localparam logic [3:0] OFF_SMASK    = 4'd2;  // single mask bit
    localparam logic [3:0] OFF_MODE     = 4'd3;  // channel mode
    localparam logic [3:0] OFF_CLRPTR   = 4'd4;  // clear byte pointer
    localparam logic [3:0] OFF_MCLR     = 4'd5;  // master clear
    localparam logic [3:0] OFF_CLRMASK  = 4'd6;  // clear all masks
    localparam logic [3:0] OFF_WRMASK   = 4'd7;  // write all masks
    localparam logic [3:0] OFF_TEMP     = 4'd8;  // temporary (reads 0)

    typedef enum logic [1:0] {
        XFER_VERIFY  = 2'd0,
        XFER_WRITE   = 2'd1,
        XFER_READ    = 2'd2,
        XFER_ILLEGAL = 2'd3
    } xfer_type_e;

    typedef enum logic [1:0] {
        MODE_DEMAND  = 2'd0,
        MODE_SINGLE  = 2'd1,
        MODE_BLOCK   = 2'd2,
        MODE_CASCADE = 2'd3
    } op_mode_e;

    // Field order matches the packed mode output {type, autoinit, dec, mode}.
    typedef struct packed {
        xfer_type_e xtype;
        logic       autoinit;
        logic       dec;
        op_mode_e   op;
    } mode_t;

    // Bits 7:6 together freeze channel 0's address (memory-to-memory source).
    typedef struct packed {
        logic       hold_en;    // bit 7
        logic       hold_sel;   // bit 6
        logic [5:0] rsvd;       // bits 5:0, stored and exported only
    } command_t;

    // Channel 0 keeps a fixed address while both hold bits are set.
    function automatic logic addr_hold(input command_t cmd, input logic is_ch0);
        return cmd.hold_en & cmd.hold_sel & is_ch0;
    endfunction

endpackage

// File: rtl/dma_channel_counter.sv
// -----------------------------------------------------------------------------
// dma_channel_counter
// One DMA channel's base/current address and word-count registers.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   srst           synchronous clear (master clear)
//   byte_sel       byte lane for CPU writes (0 = LSB)
//   wr_addr/wr_cnt CPU write strobe for address / count register
//   wr_data        CPU write byte
//   step           one word transferred on this channel
//   dec, hold      address direction / address freeze
//   autoinit       reload current from base on terminal count
//   cur_addr/cur_cnt  current registers
//   tc_hit         combinational: this step takes count from 0 to all ones
// -----------------------------------------------------------------------------
module dma_channel_counter
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int PTR_W  = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              srst,
    input  logic [PTR_W-1:0]  byte_sel,
    input  logic              wr_addr,
    input  logic              wr_cnt,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              step,
    input  logic              dec,
    input  logic              hold,
    input  logic              autoinit,
    output logic [ADDR_W-1:0] cur_addr,
    output logic [ADDR_W-1:0] cur_cnt,
    output logic              tc_hit
);

    localparam int NBYTES = ADDR_W / DATA_W;
    localparam logic [ADDR_W-1:0] ZERO = {ADDR_W{1'b0}};
    localparam logic [ADDR_W-1:0] ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [ADDR_W-1:0] base_addr_r;
    logic [ADDR_W-1:0] base_cnt_r;
    logic [ADDR_W-1:0] cur_addr_r;
    logic [ADDR_W-1:0] cur_cnt_r;
    logic              step_s;

    // A CPU write to either current register wins over a same-cycle step.
    assign step_s   = step & ~(wr_addr | wr_cnt);
    assign tc_hit   = step_s & (cur_cnt_r == ZERO);
    assign cur_addr = cur_addr_r;
    assign cur_cnt  = cur_cnt_r;

    // Base/current registers: bytewise CPU load, transfer step, autoinit reload.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            base_addr_r <= ZERO;
            base_cnt_r  <= ZERO;
            cur_addr_r  <= ZERO;
            cur_cnt_r   <= ZERO;
        end else if (srst) begin
            base_addr_r <= ZERO;
            base_cnt_r  <= ZERO;
            cur_addr_r  <= ZERO;
            cur_cnt_r   <= ZERO;
        end else begin
            for (int b = 0; b < NBYTES; b++) begin
                if (byte_sel == PTR_W'(b)) begin
                    if (wr_addr) begin
                        base_addr_r[b*DATA_W +: DATA_W] <= wr_data;
                        cur_addr_r[b*DATA_W +: DATA_W]  <= wr_data;
                    end
                    if (wr_cnt) begin
                        base_cnt_r[b*DATA_W +: DATA_W] <= wr_data;
                        cur_cnt_r[b*DATA_W +: DATA_W]  <= wr_data;
                    end
                end
            end
            if (step_s) begin
                if (tc_hit && autoinit) begin
                    cur_addr_r <= base_addr_r;
                    cur_cnt_r  <= base_cnt_r;
                end else begin
                    cur_cnt_r <= cur_cnt_r - ONE;
                    if (!hold) begin
                        cur_addr_r <= dec ? (cur_addr_r - ONE) : (cur_addr_r + ONE);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dma_channel_regfile.sv
// -----------------------------------------------------------------------------
// dma_channel_regfile
// DMA controller register file: NUM_CH channel counters plus command, mode,
// mask, request and status registers, accessed bytewise via a byte pointer.
// Ports:
//   clk, reset_n       clock, asynchronous active-low reset
//   reg_wr, reg_rd     one-cycle CPU write / read strobes
//   reg_addr, wr_data  register select and write byte
//   rd_data            read byte, valid the cycle after reg_rd
//   xfer_step, xfer_ch one word moved on channel xfer_ch
//   cur_addr           current address of xfer_ch (combinational)
//   tc                 one-cycle terminal-count pulse
//   command, mode, mask, sw_req, tc_status   register contents
// -----------------------------------------------------------------------------
module dma_channel_regfile
    import dma_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int ADDR_W = 16,
    parameter  int DATA_W = 8,
    localparam int NBYTES = ADDR_W / DATA_W,
    localparam int REG_AW = $clog2(2*NUM_CH+9),
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                reg_wr,
    input  logic                reg_rd,
    input  logic [REG_AW-1:0]   reg_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data,
    input  logic                xfer_step,
    input  logic [CH_W-1:0]     xfer_ch,
    output logic [ADDR_W-1:0]   cur_addr,
    output logic                tc,
    output logic [7:0]          command,
    output logic [NUM_CH*6-1:0] mode,
    output logic [NUM_CH-1:0]   mask,
    output logic [NUM_CH-1:0]   sw_req,
    output logic [NUM_CH-1:0]   tc_status
);

    localparam int PTR_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int GBASE = 2 * NUM_CH;

    logic [PTR_W-1:0]  ptr_r;
    command_t          command_r;
    mode_t             mode_r [NUM_CH];
    logic [NUM_CH-1:0] mask_r, sw_req_r, tc_status_r;
    logic              tc_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              is_chan_s, goff_vld_s;
    logic [CH_W-1:0]   reg_ch_s, wch_s;
    logic [3:0]        goff_s;
    logic              wr_cmd_s, wr_req_s, wr_smask_s, wr_mode_s, wr_clrptr_s;
    logic              wr_mclr_s, wr_clrmask_s, wr_wrmask_s, rd_status_s;
    logic [NUM_CH-1:0] wr_addr_s, wr_cnt_s, ch_step_s, tc_hit_s;
    logic [ADDR_W-1:0] ch_addr_s [NUM_CH];
    logic [ADDR_W-1:0] ch_cnt_s  [NUM_CH];
    logic [ADDR_W-1:0] sel_word_s;
    logic [DATA_W-1:0] status_s, rd_next_s;
    logic [NUM_CH-1:0] mask_n_s, req_n_s, tcs_n_s;

    // Split the register address into a channel register or a global offset.
    always_comb begin
        is_chan_s  = 1'b0;
        goff_vld_s = 1'b0;
        reg_ch_s   = CH_W'(reg_addr >> 1);
        goff_s     = 4'd0;
        if (int'(reg_addr) < GBASE) begin
            is_chan_s = 1'b1;
        end else if (int'(reg_addr) <= GBASE + int'(OFF_TEMP)) begin
            goff_vld_s = 1'b1;
            goff_s     = 4'(int'(reg_addr) - GBASE);
        end else begin
            goff_vld_s = 1'b0;
        end
    end

    // Global register strobes.
    always_comb begin
        wr_cmd_s     = 1'b0;
        wr_req_s     = 1'b0;
        wr_smask_s   = 1'b0;
        wr_mode_s    = 1'b0;
        wr_clrptr_s  = 1'b0;
        wr_mclr_s    = 1'b0;
        wr_clrmask_s = 1'b0;
        wr_wrmask_s  = 1'b0;
        rd_status_s  = 1'b0;
        if (goff_vld_s) begin
            case (goff_s)
                OFF_CMD:     begin wr_cmd_s = reg_wr; rd_status_s = reg_rd; end
                OFF_REQ:     wr_req_s     = reg_wr;
                OFF_SMASK:   wr_smask_s   = reg_wr;
                OFF_MODE:    wr_mode_s    = reg_wr;
                OFF_CLRPTR:  wr_clrptr_s  = reg_wr;
                OFF_MCLR:    wr_mclr_s    = reg_wr;
                OFF_CLRMASK: wr_clrmask_s = reg_wr;
                OFF_WRMASK:  wr_wrmask_s  = reg_wr;
                default:     wr_cmd_s     = 1'b0;
            endcase
        end else begin
            wr_cmd_s = 1'b0;
        end
    end

    // Per-channel write and step strobes.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wr_addr_s[c] = reg_wr & is_chan_s & (reg_ch_s == CH_W'(c)) & ~reg_addr[0];
            wr_cnt_s[c]  = reg_wr & is_chan_s & (reg_ch_s == CH_W'(c)) &  reg_addr[0];
            ch_step_s[c] = xfer_step & (xfer_ch == CH_W'(c));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dma_channel_counter #(
            .ADDR_W (ADDR_W),
            .DATA_W (DATA_W),
            .PTR_W  (PTR_W)
        ) u_counter (
            .clk      (clk),
            .reset_n  (reset_n),
            .srst     (wr_mclr_s),
            .byte_sel (ptr_r),
            .wr_addr  (wr_addr_s[g]),
            .wr_cnt   (wr_cnt_s[g]),
            .wr_data  (wr_data),
            .step     (ch_step_s[g]),
            .dec      (mode_r[g].dec),
            .hold     (addr_hold(command_r, (g == 0))),
            .autoinit (mode_r[g].autoinit),
            .cur_addr (ch_addr_s[g]),
            .cur_cnt  (ch_cnt_s[g]),
            .tc_hit   (tc_hit_s[g])
        );
        assign mode[g*6 +: 6] = mode_r[g];
    end

    // Current address of the channel being serviced.
    always_comb begin
        cur_addr = {ADDR_W{1'b0}};
        if (int'(xfer_ch) < NUM_CH) begin
            cur_addr = ch_addr_s[xfer_ch];
        end else begin
            cur_addr = {ADDR_W{1'b0}};
        end
    end

    // Read mux: channel byte at the pointer, status, everything else zero.
    always_comb begin
        status_s   = DATA_W'({sw_req_r, tc_status_r});
        sel_word_s = {ADDR_W{1'b0}};
        rd_next_s  = {DATA_W{1'b0}};
        if (is_chan_s) begin
            sel_word_s = reg_addr[0] ? ch_cnt_s[reg_ch_s] : ch_addr_s[reg_ch_s];
            rd_next_s  = DATA_W'(sel_word_s >> (int'(ptr_r) * DATA_W));
        end else if (goff_vld_s && (goff_s == OFF_CMD)) begin
            rd_next_s = status_s;
        end else begin
            rd_next_s = {DATA_W{1'b0}};
        end
    end

    // Next mask/request/status: CPU writes first, then terminal-count effects,
    // so a TC set wins over a same-cycle mask write or status-read clear.
    always_comb begin
        wch_s = wr_data[CH_W-1:0];
        if (wr_smask_s && (int'(wch_s) < NUM_CH)) begin
            mask_n_s        = mask_r;
            mask_n_s[wch_s] = wr_data[2];
        end else if (wr_clrmask_s) begin
            mask_n_s = {NUM_CH{1'b0}};
        end else if (wr_wrmask_s) begin
            mask_n_s = wr_data[NUM_CH-1:0];
        end else begin
            mask_n_s = mask_r;
        end
        if (wr_req_s && (int'(wch_s) < NUM_CH)) begin
            req_n_s        = sw_req_r;
            req_n_s[wch_s] = wr_data[2];
        end else begin
            req_n_s = sw_req_r;
        end
        tcs_n_s = rd_status_s ? {NUM_CH{1'b0}} : tc_status_r;
        for (int c = 0; c < NUM_CH; c++) begin
            tcs_n_s[c]  = tcs_n_s[c] | tc_hit_s[c];
            mask_n_s[c] = mask_n_s[c] | (tc_hit_s[c] & ~mode_r[c].autoinit);
            req_n_s[c]  = req_n_s[c] & ~(tc_hit_s[c] & ~mode_r[c].autoinit);
        end
    end

    // Global registers, byte pointer, read data and TC pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r       <= {PTR_W{1'b0}};
            command_r   <= command_t'(8'd0);
            mask_r      <= {NUM_CH{1'b1}};
            sw_req_r    <= {NUM_CH{1'b0}};
            tc_status_r <= {NUM_CH{1'b0}};
            tc_r        <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) mode_r[c] <= mode_t'(6'd0);
        end else if (wr_mclr_s) begin
            ptr_r       <= {PTR_W{1'b0}};
            command_r   <= command_t'(8'd0);
            mask_r      <= {NUM_CH{1'b1}};
            sw_req_r    <= {NUM_CH{1'b0}};
            tc_status_r <= {NUM_CH{1'b0}};
            tc_r        <= 1'b0;
            rd_data_r   <= {DATA_W{1'b0}};
            for (int c = 0; c < NUM_CH; c++) mode_r[c] <= mode_t'(6'd0);
        end else begin
            if (wr_clrptr_s) begin
                ptr_r <= {PTR_W{1'b0}};
            end else if (is_chan_s && (reg_wr || reg_rd)) begin
                ptr_r <= (int'(ptr_r) == NBYTES - 1) ? {PTR_W{1'b0}} : ptr_r + PTR_W'(1'b1);
            end
            if (wr_cmd_s) command_r <= command_t'(wr_data[7:0]);
            // Mode channel field is wr_data[1:0]; channels above 3 are not addressable.
            for (int c = 0; c < NUM_CH; c++) begin
                if (wr_mode_s && (wr_data[1:0] == 2'(c))) mode_r[c] <= mode_t'(wr_data[7:2]);
            end
            if (reg_rd) rd_data_r <= rd_next_s;
            mask_r      <= mask_n_s;
            sw_req_r    <= req_n_s;
            tc_status_r <= tcs_n_s;
            tc_r        <= |tc_hit_s;
        end
    end

    assign rd_data   = rd_data_r;
    assign tc        = tc_r;
    assign command   = command_r;
    assign mask      = mask_r;
    assign sw_req    = sw_req_r;
    assign tc_status = tc_status_r;

endmodule

// File: tb/tb_dma_channel_regfile.sv
// -----------------------------------------------------------------------------
// tb_dma_channel_regfile
// Directed stimulus with hand-computed expectations pushed into two queues:
// read data (popped when a read's data is due) and register/state snapshots
// (popped on the next falling edge). A monitor compares and counts.
// -----------------------------------------------------------------------------
module tb_dma_channel_regfile;

    localparam int NUM_CH = 4;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int REG_AW = 5;
    localparam int CH_W   = 2;

    localparam int K_RD   = 0;
    localparam int K_MASK = 1;
    localparam int K_CMD  = 2;
    localparam int K_CUR  = 3;
    localparam int K_TC   = 4;
    localparam int K_TCS  = 5;
    localparam int K_REQ  = 6;
    localparam int K_MODE = 7;
    localparam int K_RDD  = 8;

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic                reg_wr = 1'b0;
    logic                reg_rd = 1'b0;
    logic [REG_AW-1:0]   reg_addr = 5'd0;
    logic [DATA_W-1:0]   wr_data = 8'd0;
    logic [DATA_W-1:0]   rd_data;
    logic                xfer_step = 1'b0;
    logic [CH_W-1:0]     xfer_ch = 2'd0;
    logic [ADDR_W-1:0]   cur_addr;
    logic                tc;
    logic [7:0]          command;
    logic [NUM_CH*6-1:0] mode;
    logic [NUM_CH-1:0]   mask;
    logic [NUM_CH-1:0]   sw_req;
    logic [NUM_CH-1:0]   tc_status;

    always #5 clk = ~clk;

    dma_channel_regfile #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .xfer_step (xfer_step),
        .xfer_ch   (xfer_ch),
        .cur_addr  (cur_addr),
        .tc        (tc),
        .command   (command),
        .mode      (mode),
        .mask      (mask),
        .sw_req    (sw_req),
        .tc_status (tc_status)
    );

    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t rd_q[$];
    exp_t st_q[$];
    int   errors = 0;
    int   checks = 0;
    logic rd_vld_r = 1'b0;

    function automatic logic [31:0] actual(input int k);
        case (k)
            K_MASK:  return 32'(mask);
            K_CMD:   return 32'(command);
            K_CUR:   return 32'(cur_addr);
            K_TC:    return 32'(tc);
            K_TCS:   return 32'(tc_status);
            K_REQ:   return 32'(sw_req);
            K_MODE:  return 32'(mode);
            K_RDD:   return 32'(rd_data);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic compare(input exp_t e, input logic [31:0] act);
        checks++;
        if (act !== e.exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", e.name, act, e.exp);
        end
    endtask

    // Read data is due one cycle after the strobe.
    always @(posedge clk) rd_vld_r <= reg_rd;

    // Monitor: compare read data when due, and drain pending state snapshots.
    always @(negedge clk) begin
        exp_t e;
        if (rd_vld_r) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected: got 0x%0h expected no read data", rd_data);
            end else begin
                e = rd_q.pop_front();
                compare(e, 32'(rd_data));
            end
        end
        while (st_q.size() > 0) begin
            e = st_q.pop_front();
            compare(e, actual(e.kind));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d);
        reg_addr = REG_AW'(a);
        wr_data  = DATA_W'(d);
        reg_wr   = 1'b1;
        cyc();
        reg_wr   = 1'b0;
    endtask

    task automatic rd(input int a, input int d, input string n);
        rd_q.push_back('{n, K_RD, 32'(d)});
        reg_addr = REG_AW'(a);
        reg_rd   = 1'b1;
        cyc();
        reg_rd   = 1'b0;
    endtask

    task automatic chk(input int k, input int d, input string n);
        st_q.push_back('{n, k, 32'(d)});
    endtask

    task automatic step(input int c);
        xfer_ch   = CH_W'(c);
        xfer_step = 1'b1;
        cyc();
        xfer_step = 1'b0;
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk(K_MASK, 'hF, "rst_mask");
        chk(K_CMD,  'h0, "rst_cmd");
        chk(K_TCS,  'h0, "rst_tcs");
        chk(K_RDD,  'h0, "rst_rd_data");
        cyc();
        reset_n = 1'b1;
        cyc();
        rd(8, 'h00, "rst_status");

        // Byte-pointer programming of channel 1
        wr(12, 0);
        wr(2, 'h34); wr(2, 'h12);
        wr(3, 'h02); wr(3, 'h00);
        rd(2, 'h34, "ch1_addr_lsb");
        rd(2, 'h12, "ch1_addr_msb");
        rd(2, 'h34, "ch1_ptr_wrap");
        wr(12, 0);
        rd(3, 'h02, "ch1_cnt_lsb");
        rd(3, 'h00, "ch1_cnt_msb");
        xfer_ch = 2'd1;
        chk(K_CUR, 'h1234, "ch1_cur_init");

        // Channel 1: increment, no autoinit, three steps to TC
        wr(11, 'h45);
        chk(K_MODE, 'h000440, "mode_ch1");
        wr(10, 'h01);
        chk(K_MASK, 'hD, "unmask_ch1");
        wr(9, 'h05);
        chk(K_REQ, 'h2, "req_set_ch1");
        step(1);
        chk(K_CUR, 'h1235, "ch1_step1");
        chk(K_TC, 0, "ch1_no_tc1");
        step(1);
        chk(K_CUR, 'h1236, "ch1_step2");
        step(1);
        chk(K_CUR, 'h1237, "ch1_step3");
        chk(K_TC, 1, "ch1_tc");
        chk(K_TCS, 'h2, "ch1_tcs");
        chk(K_MASK, 'hF, "ch1_tc_mask");
        chk(K_REQ, 'h0, "ch1_tc_req_clr");
        cyc();
        chk(K_TC, 0, "ch1_tc_pulse_end");
        rd(3, 'hFF, "ch1_cnt_wrapped");
        wr(12, 0);

        // Channel 2: decrement with autoinit
        wr(4, 'h00); wr(4, 'h80);
        wr(5, 'h01); wr(5, 'h00);
        wr(11, 'h76);
        chk(K_MODE, 'h01D440, "mode_ch2");
        wr(10, 'h02);
        chk(K_MASK, 'hB, "unmask_ch2");
        step(2);
        chk(K_CUR, 'h7FFF, "ch2_step1");
        chk(K_TC, 0, "ch2_no_tc1");
        step(2);
        chk(K_CUR, 'h8000, "ch2_reload_addr");
        chk(K_TC, 1, "ch2_tc");
        chk(K_TCS, 'h6, "ch2_tcs");
        chk(K_MASK, 'hB, "ch2_mask_kept");
        rd(5, 'h01, "ch2_reload_cnt_lsb");
        rd(5, 'h00, "ch2_reload_cnt_msb");

        // Status clear-on-read, and a TC arriving in the same cycle as a read
        rd(8, 'h06, "status_tc12");
        chk(K_TCS, 'h0, "status_cleared");
        rd_q.push_back('{"status_race_data", K_RD, 32'h00});
        reg_addr  = 5'd8;
        reg_rd    = 1'b1;
        xfer_ch   = 2'd0;
        xfer_step = 1'b1;
        cyc();
        reg_rd    = 1'b0;
        xfer_step = 1'b0;
        chk(K_TCS, 'h1, "status_race_tc_wins");
        chk(K_TC, 1, "ch0_tc");
        rd(8, 'h01, "status_tc0");
        chk(K_TCS, 'h0, "status_second_clear");
        wr(9, 'h07);
        rd(8, 'h80, "status_swreq3");
        rd(20, 'h00, "unmapped_read");
        rd(8, 'h80, "status_swreq3_again");
        rd(16, 'h00, "temp_read");

        // Command hold of channel 0 address, then write beating a step
        wr(8, 'hC0);
        chk(K_CMD, 'hC0, "cmd_write");
        step(0);
        chk(K_CUR, 'h0001, "ch0_addr_hold");
        chk(K_TC, 0, "ch0_no_tc");
        wr(8, 'h40);
        step(0);
        chk(K_CUR, 'h0002, "ch0_addr_inc");
        reg_addr  = 5'd0;
        wr_data   = 8'h55;
        reg_wr    = 1'b1;
        xfer_ch   = 2'd0;
        xfer_step = 1'b1;
        cyc();
        reg_wr    = 1'b0;
        xfer_step = 1'b0;
        chk(K_CUR, 'h0055, "write_beats_step");
        wr(12, 0);

        // Asynchronous reset right after a TC edge
        rd(8, 'h80, "status_pre_reset");
        step(2);
        chk(K_CUR, 'h7FFF, "ch2_pre_reset");
        step(2);
        reset_n = 1'b0;
        chk(K_TC,   0,     "areset_tc");
        chk(K_TCS,  'h0,   "areset_tcs");
        chk(K_MASK, 'hF,   "areset_mask");
        chk(K_CMD,  'h0,   "areset_cmd");
        chk(K_REQ,  'h0,   "areset_req");
        chk(K_MODE, 'h0,   "areset_mode");
        chk(K_CUR,  'h0,   "areset_cur");
        chk(K_RDD,  'h0,   "areset_rd_data");
        cyc(); cyc();
        reset_n = 1'b1;
        cyc();

        // Master clear
        wr(11, 'h45);
        wr(10, 'h01);
        chk(K_MASK, 'hD, "pre_mclr_mask");
        wr(13, 0);
        chk(K_MASK, 'hF, "mclr_mask");
        chk(K_MODE, 'h0, "mclr_mode");

        cyc(); cyc();
        checks++;
        if (rd_q.size() != 0 || st_q.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d pending expected 0", rd_q.size() + st_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
